cmt_seq_ctrl: RTL and testbench
===============================

CMT_SEQ_CTRL -- requirements
Module: cmt_seq_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles cmt_reset is held asserted per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024: cycles allowed for lock after cmt_reset release.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8: gate-off cycles before and after a mux select change.
REQ-004 SHALL have parameter MAX_RETRY, default 3: reset attempts before FAULT.
REQ-005 SHALL have port clk, input, 1: single clock (the CMT input clock); all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port locked, input, 1: CMT LOCKED, asynchronous to clk.
REQ-008 SHALL have port sel_req, input, 2: requested mux source (0 = clk, 1 = clk1, 2 = clk2; 3 illegal).
REQ-009 SHALL have port sel_valid, input, 1: sel_req is valid.
REQ-010 SHALL have port sel_ready, output, 1: request accepted when sel_valid && sel_ready.
REQ-011 SHALL have port cmt_reset, output, 1: active-high reset to the CMT.
REQ-012 SHALL have port mux_sel, output, 2: select to the clock mux.
REQ-013 SHALL have port mux_en, output, 1: output-clock gate enable.
REQ-014 SHALL have port running, output, 1: high only in RUN.
REQ-015 SHALL have port fault, output, 1: sticky; high in FAULT.
REQ-016 SHALL have port retry_cnt, output, 2: attempts consumed.

Function
REQ-017 locked SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value (2-cycle latency).
REQ-018 States SHALL be RST, WAIT_LOCK, RUN, GATE_OFF, SWITCH, GATE_ON, FAULT.
- RST: cmt_reset=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK: cmt_reset=0; sync locked=1 -> RUN. Timeout at LOCK_TIMEOUT cycles -> retry_cnt+1 and RST; if retry_cnt+1 == MAX_RETRY -> FAULT instead.
- RUN: mux_en=1, sel_ready=1; accepted legal request with sel_req != mux_sel -> GATE_OFF; accepted sel_req == mux_sel -> stay in RUN, no other effect.
- GATE_OFF: mux_en=0 for SETTLE_CYCLES cycles, then SWITCH.
- SWITCH: mux_sel <= latched request, one cycle, then GATE_ON.
- GATE_ON: mux_en=0 for SETTLE_CYCLES cycles, then RUN.
- FAULT: cmt_reset=1, mux_en=0, fault=1; exit only via rst_n.
REQ-019 sel_ready SHALL be 0 outside RUN; sel_req=3 SHALL be accepted and dropped, and SHALL NOT change mux_sel.
REQ-020 Sync locked=0 in RUN, GATE_OFF, SWITCH or GATE_ON SHALL force mux_en=0 and a transition to RST on the next cycle; any pending switch is abandoned and mux_sel is held.
REQ-021 Entry to RUN SHALL clear retry_cnt to 0.
REQ-022 Lock loss in the same cycle as an accepted request: lock loss SHALL win and the request SHALL be dropped.
REQ-023 All counters SHALL saturate and never wrap; widths SHALL be $clog2 of the largest parameter + 1.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst_n low SHALL immediately force state=RST with counters cleared, and cmt_reset=1, mux_sel=0, mux_en=0, sel_ready=0, running=0, fault=0, retry_cnt=0; the synchronizer SHALL be cleared to 0.
REQ-026 Release of rst_n mid-operation SHALL restart the full RST sequence.

Structure
REQ-027 The state encoding and the mux source constants (SRC_CLK=0, SRC_CLK1=1, SRC_CLK2=2) SHALL live in shared package cmt_pkg.
REQ-028 The locked synchronizer SHALL be sub-module sync2 (1-bit, async active-low clear).

Verification
REQ-029 Locked rises 20 cycles after cmt_reset falls -> cmt_reset high exactly 16 cycles, running=1 at 22+1 cycles, retry_cnt=0.
REQ-030 Locked never rises -> three RST/WAIT_LOCK attempts of 16+1024 cycles each, then fault=1, cmt_reset=1, retry_cnt=3 held.
REQ-031 In RUN, request sel_req=2 -> mux_en=0 for 8 cycles, mux_sel=2, mux_en=0 for 8 more cycles, then mux_en=1; sel_ready=0 throughout.
REQ-032 Locked drops during GATE_OFF -> RST within 3 cycles, mux_sel unchanged, mux_en=0, cmt_reset=1.
REQ-033 Request sel_req=3, and a request equal to the current mux_sel -> both accepted; mux_sel and mux_en unchanged.
REQ-034 rst_n pulsed low during SWITCH -> all outputs at their reset values asynchronously; full sequence restarts on release.

Source files
------------

// File: rtl/cmt_pkg.sv
// cmt_pkg: shared definitions for the clock-management-tile sequencer.
//   cmt_state_e   - sequencer state encoding
//   SRC_*         - clock mux source codes (SRC_ILLEGAL is accepted and dropped)
//   cmt_max3()    - largest of three ints, used to size the shared counter
package cmt_pkg;

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RUN       = 3'd2,
    ST_GATE_OFF  = 3'd3,
    ST_SWITCH    = 3'd4,
    ST_GATE_ON   = 3'd5,
    ST_FAULT     = 3'd6
  } cmt_state_e;

  localparam logic [1:0] SRC_CLK     = 2'd0;
  localparam logic [1:0] SRC_CLK1    = 2'd1;
  localparam logic [1:0] SRC_CLK2    = 2'd2;
  localparam logic [1:0] SRC_ILLEGAL = 2'd3;

  function automatic int cmt_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level.
//   clk   - destination clock
//   rst_n - asynchronous active-low clear (both flops to 0)
//   d     - asynchronous input
//   q     - synchronized output, two rising edges of latency
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmt_seq_ctrl.sv
// cmt_seq_ctrl: brings up a clock-management tile (reset, wait for lock,
// bounded retries) and performs glitch-free clock mux source switches.
//   clk        - CMT input clock
//   rst_n      - asynchronous active-low reset
//   locked     - CMT LOCKED, asynchronous, synchronized internally
//   sel_req    - requested mux source (3 is illegal and dropped)
//   sel_valid  - sel_req valid; accepted when sel_ready is high
//   sel_ready  - high only in RUN
//   cmt_reset  - active-high reset to the CMT
//   mux_sel    - clock mux select
//   mux_en     - output clock gate enable
//   running    - high only in RUN
//   fault      - high in FAULT (absorbing until rst_n)
//   retry_cnt  - reset attempts consumed since last RUN
//
// state     | meaning
// RST       | cmt_reset held for RST_CYCLES
// WAIT_LOCK | cmt_reset released, waiting up to LOCK_TIMEOUT for lock
// RUN       | output clock enabled, accepting source requests
// GATE_OFF  | gate closed for SETTLE_CYCLES before the select moves
// SWITCH    | one cycle, select takes the latched request
// GATE_ON   | gate still closed for SETTLE_CYCLES after the select moved
// FAULT     | retries exhausted, CMT held in reset until rst_n
module cmt_seq_ctrl
  import cmt_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic [1:0] sel_req,
  input  logic       sel_valid,
  output logic       sel_ready,
  output logic       cmt_reset,
  output logic [1:0] mux_sel,
  output logic       mux_en,
  output logic       running,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int CNT_W = $clog2(cmt_max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  cmt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       req_q, req_d;
  logic [1:0]       retry_d;
  logic             locked_s;
  logic             accept;

  sync2 u_sync_locked (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  assign accept = sel_valid && sel_ready;

  // Lock loss is checked before any request in the clocked states, so a
  // request accepted in the same cycle is simply dropped.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    retry_d = retry_cnt;
    case (state_q)
      ST_RST: begin
        if (cnt_q == RST_TC) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_RUN;
        end else if (cnt_q == LOCK_TC) begin
          retry_d = (retry_cnt == 2'b11) ? retry_cnt : retry_cnt + 2'd1;
          state_d = (int'(retry_cnt) + 1 >= MAX_RETRY) ? ST_FAULT : ST_RST;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_RST;
        end else if (accept && sel_req != SRC_ILLEGAL && sel_req != mux_sel) begin
          req_d   = sel_req;
          state_d = ST_GATE_OFF;
        end
      end
      ST_GATE_OFF: begin
        if (!locked_s)                state_d = ST_RST;
        else if (cnt_q == SETTLE_TC)  state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (!locked_s) state_d = ST_RST;
        else           state_d = ST_GATE_ON;
      end
      ST_GATE_ON: begin
        if (!locked_s)                state_d = ST_RST;
        else if (cnt_q == SETTLE_TC)  state_d = ST_RUN;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RST;
    endcase
    if (state_d == ST_RUN) retry_d = 2'd0;
  end

  // Outputs are registered from the next state so they line up with the
  // state register; mux_sel only moves on the edge that enters SWITCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      cnt_q     <= '0;
      req_q     <= SRC_CLK;
      sel_ready <= 1'b0;
      cmt_reset <= 1'b1;
      mux_sel   <= SRC_CLK;
      mux_en    <= 1'b0;
      running   <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 2'd0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      retry_cnt <= retry_d;
      if (state_d != state_q)  cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      cmt_reset <= (state_d == ST_RST) || (state_d == ST_FAULT);
      sel_ready <= (state_d == ST_RUN);
      mux_en    <= (state_d == ST_RUN);
      running   <= (state_d == ST_RUN);
      fault     <= (state_d == ST_FAULT);
      if (state_d == ST_SWITCH) mux_sel <= req_q;
    end
  end

endmodule

// File: tb/tb_cmt_seq_ctrl.sv
// tb_cmt_seq_ctrl: self-checking bench for cmt_seq_ctrl with default
// parameters. Expected timings come from the sequencing rules as plain
// arithmetic (attempt length, sync latency, gate windows) and a tracked
// "current source" value.
module tb_cmt_seq_ctrl;

  localparam int RST_C  = 16;
  localparam int LOCK_T = 1024;
  localparam int SETTLE = 8;
  localparam int MAXR   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic [1:0] sel_req = 2'd0;
  logic       sel_valid = 1'b0;
  logic       sel_ready, cmt_reset, mux_en, running, fault;
  logic [1:0] mux_sel, retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_src = 0;

  cmt_seq_ctrl #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (LOCK_T),
    .SETTLE_CYCLES (SETTLE),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .locked    (locked),
    .sel_req   (sel_req),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .cmt_reset (cmt_reset),
    .mux_sel   (mux_sel),
    .mux_en    (mux_en),
    .running   (running),
    .fault     (fault),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmt_reset"}, cmt_reset, 1);
    chk({tag, "_mux_sel"},   mux_sel,   0);
    chk({tag, "_mux_en"},    mux_en,    0);
    chk({tag, "_sel_ready"}, sel_ready, 0);
    chk({tag, "_running"},   running,   0);
    chk({tag, "_fault"},     fault,     0);
    chk({tag, "_retry_cnt"}, retry_cnt, 0);
  endtask

  // Called at the negedge right after rst_n release with locked low.
  task automatic bring_up(input int dly);
    int n;
    n = 0;
    do begin tick(); n++; end while (cmt_reset && n < 100);
    chk("rst_len", n, RST_C);
    n = 0;
    repeat (dly) begin tick(); n++; end
    locked = 1'b1;
    while (!running && n < dly + 50) begin tick(); n++; end
    chk("lock_to_run", n, dly + 3);
    chk("run_retry", retry_cnt, 0);
    chk("run_mux_en", mux_en, 1);
    chk("run_ready", sel_ready, 1);
    chk("run_mux_sel", mux_sel, 0);
    cur_src = 0;
  endtask

  task automatic present(input int r);
    sel_req   = 2'(r);
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic req_switch(input int r);
    int old, n_low, n_old, bad;
    old = cur_src; n_low = 0; n_old = 0; bad = 0;
    present(r);
    while (!mux_en && n_low < 100) begin
      if (mux_sel == 2'(old)) n_old++;
      if (sel_ready) bad++;
      n_low++;
      tick();
    end
    chk("sw_gate_low", n_low, 2 * SETTLE + 1);
    chk("sw_old_sel", n_old, SETTLE);
    chk("sw_ready_low", bad, 0);
    chk("sw_new_sel", mux_sel, r);
    cur_src = r;
  endtask

  task automatic req_ignored(input int r);
    int bad;
    bad = 0;
    present(r);
    repeat (2 * SETTLE + 2) begin
      if (!mux_en || mux_sel != 2'(cur_src) || !sel_ready || !running) bad++;
      tick();
    end
    chk("ign_no_effect", bad, 0);
  endtask

  // Called at the first sample where RST was re-entered after lock loss.
  task automatic recover();
    int n;
    n = 0;
    locked = 1'b1;
    while (!running && n < 200) begin tick(); n++; end
    chk("recover_cycles", n, RST_C + 1);
    chk("recover_sel", mux_sel, cur_src);
    chk("recover_retry", retry_cnt, 0);
  endtask

  function automatic int other_src(input int c);
    return (c + 1 + int'($urandom_range(0, 1))) % 3;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, n, d, rises, prev;

    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;
    bring_up(20);

    req_switch(2);
    req_ignored(3);
    req_ignored(2);
    for (int i = 0; i < 12; i++) begin
      r = int'($urandom_range(0, 3));
      if (r != 3 && r != cur_src) req_switch(r);
      else req_ignored(r);
    end

    // lock loss while the gate is closed before the select moves
    r = other_src(cur_src);
    present(r);
    d = int'($urandom_range(0, SETTLE - 3));
    repeat (d) tick();
    locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!cmt_reset && n < 10);
    chk("drop_latency", n, 3);
    chk("drop_sel", mux_sel, cur_src);
    chk("drop_en", mux_en, 0);
    recover();

    // lock loss coinciding with an accepted request
    r = other_src(cur_src);
    locked = 1'b0;
    tick();
    tick();
    chk("pre_loss_ready", sel_ready, 1);
    present(r);
    chk("loss_req_rst", cmt_reset, 1);
    chk("loss_req_en", mux_en, 0);
    chk("loss_req_sel", mux_sel, cur_src);
    recover();

    // asynchronous reset in the middle of a switch
    r = other_src(cur_src);
    present(r);
    repeat (SETTLE) tick();
    chk("switch_sel", mux_sel, r);
    #2;
    rst_n  = 1'b0;
    locked = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    bring_up(int'($urandom_range(1, 40)));

    // lock never arrives
    @(negedge clk);
    rst_n  = 1'b0;
    locked = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; rises = 0; prev = 1;
    while (!fault && n < 5000) begin
      tick();
      n++;
      if (cmt_reset && prev == 0) rises++;
      prev = cmt_reset;
    end
    chk("fault_cycles", n, MAXR * (RST_C + LOCK_T));
    chk("fault_reset_rises", rises, MAXR);
    chk("fault_retry", retry_cnt, MAXR);
    chk("fault_cmt_reset", cmt_reset, 1);
    chk("fault_mux_en", mux_en, 0);
    locked = 1'b1;
    repeat (50) tick();
    chk("fault_held", fault, 1);
    chk("fault_retry_held", retry_cnt, MAXR);
    chk("fault_ready", sel_ready, 0);
    chk("fault_running", running, 0);

    @(negedge clk);
    rst_n  = 1'b0;
    locked = 1'b0;
    @(negedge clk);
    chk("fault_cleared", fault, 0);
    rst_n = 1'b1;
    bring_up(5);
    req_switch(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
